// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - sums LEN unsigned products per vector, valid/ready result port
module dot_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              drop_err
);
    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               out_ovf_q;
    logic               out_valid_q;
    logic               drop_err_q;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   acc_d;
    logic               carry_d;
    logic               ovf_d;
    logic [CNT_W-1:0]   cnt_d;

    // in_ready is the only output decoded straight from the state register
    assign in_ready = (state_q != HOLD);

    always_comb begin
        in_ext           = ACC_W'(in_data);
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, in_ext};
        ovf_d            = ovf_q | carry_d;
        cnt_d            = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q <= in_ext;
                        cnt_q <= CNT_W'(1);
                        ovf_q <= 1'b0;
                        if (LEN == 1) begin
                            out_sum_q   <= in_ext;
                            out_ovf_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(LEN - 1)) begin
                            out_sum_q   <= acc_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // No bypass: the next vector starts only after the result leaves
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign drop_err  = drop_err_q;
endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - scoreboard bench for dot_accumulator
module tb_dot_accumulator;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int LEN    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              drop_err;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    dot_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one beat; returns wait cycles
    task automatic send(input logic [DATA_W-1:0] d, output int waited);
        waited = 0;
        while (!in_ready && waited < 10) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_vec(input logic [DATA_W-1:0] a, b, c, d,
                            input logic [ACC_W-1:0] esum, input logic eovf);
        int w;
        send(a, w);
        send(b, w);
        send(c, w);
        sb_q.push_back('{sum: esum, ovf: eovf});
        send(d, w);
    endtask

    // Monitor: pops the scoreboard on every output transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_sum), 64'hDEAD_0000_0000);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_sum", 64'(out_sum), 64'(e.sum));
                    chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_drop_err",  64'(drop_err),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        tick();

        // Basic vector and latency
        send(3, w);
        send(5, w);
        send(7, w);
        chk("lat_before", 64'(out_valid), 64'd0);
        sb_q.push_back('{sum: 32'd24, ovf: 1'b0});
        send(9, w);
        chk("lat_valid", 64'(out_valid), 64'd1);
        tick();
        chk("valid_one_cycle", 64'(out_valid), 64'd0);

        // Gapped input
        send(10, w);
        tick();
        send(20, w);
        tick();
        send(30, w);
        sb_q.push_back('{sum: 32'd100, ovf: 1'b0});
        send(40, w);
        tick();
        chk("gap_drop_err", 64'(drop_err), 64'd0);

        // Backpressure with beats offered while holding
        out_ready = 1'b0;
        send_vec(3, 5, 7, 9, 32'd24, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp_out_sum",   64'(out_sum),   64'd24);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("bp_drop_err", 64'(drop_err), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);

        // Overflow, then a clean vector
        send_vec(32'hFFFF_FFFF, 1, 0, 0, 32'd0, 1'b1);
        send_vec(1, 1, 1, 1, 32'd4, 1'b0);
        tick();

        // Reset mid-vector
        send(100, w);
        send(200, w);
        reset = 1'b1;
        tick();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_sum",   64'(out_sum),   64'd0);
        chk("mid_rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("mid_rst_drop_err",  64'(drop_err),  64'd0);
        reset = 1'b0;
        send_vec(1, 1, 1, 1, 32'd4, 1'b0);

        // Back-to-back vectors: second starts the cycle after xfer
        send_vec(1, 2, 3, 4, 32'd10, 1'b0);
        send(5, w);
        chk("b2b_wait_cycles", 64'(w), 64'd1);
        send(6, w);
        send(7, w);
        sb_q.push_back('{sum: 32'd26, ovf: 1'b0});
        send(8, w);
        tick();
        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("final_drop_err", 64'(drop_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
